// File: rtl/inst_fetch_cache_pkg.sv
// Shared definitions for the instruction fetch cache: default geometry,
// controller state codes and the memory-to-CPU byte-lane reversal.
package inst_fetch_cache_pkg;

  localparam int ICACHE_INDEX_BITS = 4;
  localparam int ICACHE_WORD_BITS  = 2;
  localparam int INST_W            = 32;

  typedef enum logic [0:0] {
    ST_LOOKUP = 1'b0,
    ST_REFILL = 1'b1
  } icache_state_t;

  function automatic logic [INST_W-1:0] swap_bytes(input logic [INST_W-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/icache_data_ram.sv
// Instruction cache data store: one asynchronous read port for the fetch
// path, one synchronous write port for line refill.
module icache_data_ram
  import inst_fetch_cache_pkg::*;
#(
  parameter int ADDR_BITS = 6
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [ADDR_BITS-1:0] i_waddr,
  input  logic [INST_W-1:0]    i_wdata,
  input  logic [ADDR_BITS-1:0] i_raddr,
  output logic [INST_W-1:0]    o_rdata
);

  logic [INST_W-1:0] r_mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/inst_fetch_cache.sv
// Direct-mapped read-only instruction cache: same-cycle hits, stalled
// whole-line burst refill over a req/ack bus, optional byte-lane reversal.
module inst_fetch_cache
  import inst_fetch_cache_pkg::*;
#(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS,
  parameter int WORD_BITS  = ICACHE_WORD_BITS,
  parameter int SWAP_BYTES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_ce_i,
  input  logic [31:0]       cpu_addr_i,
  output logic [INST_W-1:0] cpu_inst_o,
  output logic              stall_o,
  input  logic              flush_i,
  output logic              mem_req_o,
  output logic [31:0]       mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [INST_W-1:0] mem_data_i,
  output logic              dbg_state_o
);

  localparam int LINES     = 2**INDEX_BITS;
  localparam int TAG_BITS  = 32 - INDEX_BITS - WORD_BITS - 2;
  localparam int LINE_BITS = 32 - WORD_BITS - 2;
  localparam logic [WORD_BITS-1:0] LAST_WORD = '1;

  icache_state_t         r_state;
  icache_state_t         w_state_nxt;
  logic [LINES-1:0]      r_valid;
  logic [TAG_BITS-1:0]   r_tag [LINES];
  logic [LINE_BITS-1:0]  r_line;
  logic [WORD_BITS-1:0]  r_cnt;
  logic                  r_flush_pend;

  logic [WORD_BITS-1:0]  w_offset;
  logic [INDEX_BITS-1:0] w_index;
  logic [TAG_BITS-1:0]   w_tag;
  logic [INDEX_BITS-1:0] w_line_index;
  logic                  w_hit;
  logic                  w_miss;
  logic                  w_ack;
  logic                  w_last;
  logic [INST_W-1:0]     w_rd_data;
  logic [INST_W-1:0]     w_word;
  logic                  w_unused_addr_lsb;

  assign w_offset          = cpu_addr_i[WORD_BITS+1:2];
  assign w_index           = cpu_addr_i[WORD_BITS+INDEX_BITS+1:WORD_BITS+2];
  assign w_tag             = cpu_addr_i[31:WORD_BITS+INDEX_BITS+2];
  assign w_unused_addr_lsb = ^cpu_addr_i[1:0];
  assign w_line_index      = r_line[INDEX_BITS-1:0];

  assign w_hit  = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_miss = (r_state == ST_LOOKUP) && cpu_ce_i && !w_hit;
  // Bus handshake: a word transfers in any cycle where mem_req_o and mem_ack_i
  // are both high; req and addr stay stable until that cycle, and the next
  // word's request follows immediately with no idle cycle.
  assign w_ack  = (r_state == ST_REFILL) && mem_ack_i;
  assign w_last = w_ack && (r_cnt == LAST_WORD);

  assign w_word      = (SWAP_BYTES != 0) ? swap_bytes(w_rd_data) : w_rd_data;
  assign dbg_state_o = r_state;

  icache_data_ram #(
    .ADDR_BITS(INDEX_BITS + WORD_BITS)
  ) u_data_ram (
    .clk     (clk),
    .i_we    (w_ack),
    .i_waddr ({w_line_index, r_cnt}),
    .i_wdata (mem_data_i),
    .i_raddr ({w_index, w_offset}),
    .o_rdata (w_rd_data)
  );

  always_comb begin
    w_state_nxt = r_state;
    stall_o     = 1'b0;
    cpu_inst_o  = '0;
    mem_req_o   = 1'b0;
    mem_addr_o  = '0;
    case (r_state)
      ST_LOOKUP: begin
        if (cpu_ce_i) begin
          if (w_hit) begin
            cpu_inst_o = w_word;
          end else begin
            stall_o     = 1'b1;
            w_state_nxt = ST_REFILL;
          end
        end
      end
      ST_REFILL: begin
        stall_o    = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = {r_line, r_cnt, 2'b00};
        if (w_last) begin
          w_state_nxt = ST_LOOKUP;
        end
      end
      default: w_state_nxt = ST_LOOKUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_LOOKUP;
      r_valid      <= '0;
      r_line       <= '0;
      r_cnt        <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_miss) begin
        r_line <= {w_tag, w_index};
        r_cnt  <= '0;
      end else if (w_ack) begin
        r_cnt <= r_cnt + 1'b1;
      end
      // A flush anywhere in a refill, including on its last ack, leaves the line invalid.
      if (flush_i) begin
        r_valid <= '0;
      end else if (w_last && !r_flush_pend) begin
        r_valid[w_line_index] <= 1'b1;
      end
      if (w_last) begin
        r_flush_pend <= 1'b0;
      end else if (flush_i && (r_state == ST_REFILL)) begin
        r_flush_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_last) begin
      r_tag[w_line_index] <= r_line[LINE_BITS-1:INDEX_BITS];
    end
  end

endmodule
